// File: rtl/synth_pkg.sv
// synth_pkg: shared types and constants for the synth parameter controller.
//   state_t  - request-handling FSM states
//   req_t    - latched request code
//   SEL_*    - adsr_sel encodings for the five ADSR/amplitude indices
//   *_DEFAULT- power-on / reset values
package synth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } state_t;

  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_OCT_UP,
    REQ_OCT_DN,
    REQ_ADSR_UP,
    REQ_ADSR_DN
  } req_t;

  localparam logic [2:0] SEL_AMP     = 3'd0;
  localparam logic [2:0] SEL_ATTACK  = 3'd1;
  localparam logic [2:0] SEL_DECAY   = 3'd2;
  localparam logic [2:0] SEL_SUSTAIN = 3'd3;
  localparam logic [2:0] SEL_RELEASE = 3'd4;

  localparam logic [2:0] OCT_DEFAULT = 3'd4;
  localparam logic [7:0] IDX_DEFAULT = 8'd128;
  localparam logic [7:0] DECAY_DEFAULT = 8'd0;

endpackage

// File: rtl/sat_step8.sv
// sat_step8: saturating +/-1 on an 8-bit value.
//   value   - current value
//   up      - 1: increment, 0: decrement
//   result  - stepped value (held at 0 / 255 when saturated)
//   changed - 1 when result differs from value
module sat_step8 (
  input  logic [7:0] value,
  input  logic       up,
  output logic [7:0] result,
  output logic       changed
);

  always_comb begin
    result  = value;
    changed = 1'b0;
    if (up) begin
      if (value != 8'hFF) begin
        result  = value + 8'd1;
        changed = 1'b1;
      end
    end else begin
      if (value != 8'h00) begin
        result  = value - 8'd1;
        changed = 1'b1;
      end
    end
  end

endmodule

// File: rtl/synth_param_ctrl.sv
// synth_param_ctrl: button-driven octave / ADSR parameter registers with
// press-and-hold auto-repeat.
//   clk, reset                 - clock, synchronous active-low reset
//   oct_up, oct_dn             - level requests to step the octave
//   adsr_up, adsr_dn, adsr_sel - level requests to step the selected index
//   octave                     - current octave (0-7)
//   amplitude..rel             - 8-bit index in [30:23], zeros below
//   changed                    - one-cycle pulse when any register changes
module synth_param_ctrl
  import synth_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        oct_up,
  input  logic        oct_dn,
  input  logic        adsr_up,
  input  logic        adsr_dn,
  input  logic [2:0]  adsr_sel,
  output logic [2:0]  octave,
  output logic [30:0] amplitude,
  output logic [30:0] attack,
  output logic [30:0] decay,
  output logic [30:0] sustain,
  output logic [30:0] rel,
  output logic        changed
);

  localparam int unsigned MAXC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

  state_t        state_q, state_d;
  req_t          req_q, req_d, step_req, new_req;
  logic [2:0]    sel_q, sel_d, step_sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step, held;

  logic [2:0] oct_q;
  logic [7:0] amp_q, atk_q, dec_q, sus_q, rel_q;
  logic       changed_q;

  logic [7:0] cur_idx, nxt_idx;
  logic       idx_chg, sel_valid;

  // Opposing requests of a pair cancel each other before priority is applied.
  always_comb begin
    new_req = REQ_NONE;
    if (oct_up && !oct_dn)        new_req = REQ_OCT_UP;
    else if (oct_dn && !oct_up)   new_req = REQ_OCT_DN;
    else if (adsr_up && !adsr_dn) new_req = REQ_ADSR_UP;
    else if (adsr_dn && !adsr_up) new_req = REQ_ADSR_DN;
  end

  always_comb begin
    case (req_q)
      REQ_OCT_UP:  held = oct_up;
      REQ_OCT_DN:  held = oct_dn;
      REQ_ADSR_UP: held = adsr_up;
      REQ_ADSR_DN: held = adsr_dn;
      default:     held = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    step     = 1'b0;
    step_req = req_q;
    step_sel = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (new_req != REQ_NONE) begin
          req_d    = new_req;
          sel_d    = adsr_sel;
          step     = 1'b1;
          step_req = new_req;
          step_sel = adsr_sel;
          cnt_d    = '0;
          state_d  = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (!held) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == DLY_LAST) begin
          step    = 1'b1;
          cnt_d   = '0;
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!held) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == PER_LAST) begin
          step  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One shared stepper serves whichever index the step targets.
  always_comb begin
    sel_valid = 1'b1;
    case (step_sel)
      SEL_AMP:     cur_idx = amp_q;
      SEL_ATTACK:  cur_idx = atk_q;
      SEL_DECAY:   cur_idx = dec_q;
      SEL_SUSTAIN: cur_idx = sus_q;
      SEL_RELEASE: cur_idx = rel_q;
      default: begin
        cur_idx   = '0;
        sel_valid = 1'b0;
      end
    endcase
  end

  sat_step8 u_step (
    .value   (cur_idx),
    .up      (step_req == REQ_ADSR_UP),
    .result  (nxt_idx),
    .changed (idx_chg)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      req_q     <= REQ_NONE;
      sel_q     <= '0;
      cnt_q     <= '0;
      oct_q     <= OCT_DEFAULT;
      amp_q     <= IDX_DEFAULT;
      atk_q     <= IDX_DEFAULT;
      dec_q     <= DECAY_DEFAULT;
      sus_q     <= IDX_DEFAULT;
      rel_q     <= IDX_DEFAULT;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      changed_q <= 1'b0;
      if (step) begin
        case (step_req)
          REQ_OCT_UP: if (oct_q != 3'd7) begin
            oct_q     <= oct_q + 3'd1;
            changed_q <= 1'b1;
          end
          REQ_OCT_DN: if (oct_q != 3'd0) begin
            oct_q     <= oct_q - 3'd1;
            changed_q <= 1'b1;
          end
          REQ_ADSR_UP, REQ_ADSR_DN: if (sel_valid && idx_chg) begin
            changed_q <= 1'b1;
            case (step_sel)
              SEL_AMP:     amp_q <= nxt_idx;
              SEL_ATTACK:  atk_q <= nxt_idx;
              SEL_DECAY:   dec_q <= nxt_idx;
              SEL_SUSTAIN: sus_q <= nxt_idx;
              default:     rel_q <= nxt_idx;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign octave    = oct_q;
  assign amplitude = {amp_q, 23'd0};
  assign attack    = {atk_q, 23'd0};
  assign decay     = {dec_q, 23'd0};
  assign sustain   = {sus_q, 23'd0};
  assign rel       = {rel_q, 23'd0};
  assign changed   = changed_q;

endmodule

// File: tb/tb_synth_param_ctrl.sv
// tb_synth_param_ctrl: directed scenarios plus randomized hold patterns,
// checked every cycle against a hold-duration based reference model.
module tb_synth_param_ctrl;

  localparam int RD = 10;
  localparam int RP = 4;

  logic        clk = 1'b0;
  logic        reset, oct_up, oct_dn, adsr_up, adsr_dn;
  logic [2:0]  adsr_sel;
  logic [2:0]  octave;
  logic [30:0] amplitude, attack, decay, sustain, rel;
  logic        changed;

  always #5 clk = ~clk;

  synth_param_ctrl #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset),
    .oct_up(oct_up), .oct_dn(oct_dn), .adsr_up(adsr_up), .adsr_dn(adsr_dn),
    .adsr_sel(adsr_sel),
    .octave(octave), .amplitude(amplitude), .attack(attack), .decay(decay),
    .sustain(sustain), .rel(rel), .changed(changed)
  );

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  // Reference model: values plus "how many edges has the request been held".
  int m_oct;
  int m_idx[5];
  bit m_active;
  int m_req;   // 0 oct_up, 1 oct_dn, 2 adsr_up, 3 adsr_dn
  int m_sel;
  int m_n;
  bit m_chg;

  function automatic void m_defaults();
    m_oct = 4;
    m_idx[0] = 128; m_idx[1] = 128; m_idx[2] = 0; m_idx[3] = 128; m_idx[4] = 128;
    m_active = 1'b0;
    m_n = 0;
  endfunction

  function automatic void m_step();
    case (m_req)
      0: if (m_oct < 7) begin m_oct++; m_chg = 1'b1; end
      1: if (m_oct > 0) begin m_oct--; m_chg = 1'b1; end
      2: if (m_sel < 5 && m_idx[m_sel] < 255) begin m_idx[m_sel]++; m_chg = 1'b1; end
      default: if (m_sel < 5 && m_idx[m_sel] > 0) begin m_idx[m_sel]--; m_chg = 1'b1; end
    endcase
  endfunction

  function automatic void m_edge();
    bit h;
    int r;
    m_chg = 1'b0;
    if (!reset) begin
      m_defaults();
    end else if (!m_active) begin
      r = -1;
      if (oct_up && !oct_dn)        r = 0;
      else if (oct_dn && !oct_up)   r = 1;
      else if (adsr_up && !adsr_dn) r = 2;
      else if (adsr_dn && !adsr_up) r = 3;
      if (r >= 0) begin
        m_active = 1'b1; m_req = r; m_sel = int'(adsr_sel); m_n = 0;
        m_step();
      end
    end else begin
      case (m_req)
        0: h = oct_up;
        1: h = oct_dn;
        2: h = adsr_up;
        default: h = adsr_dn;
      endcase
      if (!h) m_active = 1'b0;
      else begin
        m_n++;
        if (m_n >= RD && ((m_n - RD) % RP) == 0) m_step();
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input bit r, input bit ou, input bit od, input bit au, input bit ad,
                     input logic [2:0] sel);
    reset = r; oct_up = ou; oct_dn = od; adsr_up = au; adsr_dn = ad; adsr_sel = sel;
    @(posedge clk);
    m_edge();
    @(negedge clk);
    chk("octave",    32'(octave),    32'(m_oct));
    chk("amplitude", 32'(amplitude), 32'(m_idx[0]) << 23);
    chk("attack",    32'(attack),    32'(m_idx[1]) << 23);
    chk("decay",     32'(decay),     32'(m_idx[2]) << 23);
    chk("sustain",   32'(sustain),   32'(m_idx[3]) << 23);
    chk("rel",       32'(rel),       32'(m_idx[4]) << 23);
    chk("changed",   32'(changed),   32'(m_chg));
    if (changed) pulses++;
  endtask

  task automatic hold(input int n, input bit ou, input bit od, input bit au, input bit ad,
                      input logic [2:0] sel);
    for (int i = 0; i < n; i++) cyc(1'b1, ou, od, au, ad, sel);
  endtask

  task automatic do_reset();
    cyc(1'b0, 0, 0, 0, 0, 3'd0);
    cyc(1'b0, 0, 0, 0, 0, 3'd0);
  endtask

  initial begin
    bit [3:0] base, noise;
    logic [2:0] sel;
    int len;
    m_defaults();
    m_chg = 1'b0;

    // Reset values
    do_reset();
    chk("rst_octave", 32'(octave), 32'd4);
    chk("rst_amp", 32'(amplitude), 32'd1073741824);
    chk("rst_decay", 32'(decay), 32'd0);
    chk("rst_changed", 32'(changed), 32'd0);

    // Single oct_up pulse, then an immediate oct_dn once back in idle
    pulses = 0;
    hold(1, 1, 0, 0, 0, 3'd0);
    chk("pulse_oct5", 32'(octave), 32'd5);
    hold(3, 0, 0, 0, 0, 3'd0);
    chk("pulse_once", 32'(pulses), 32'd1);
    hold(1, 0, 0, 0, 0, 3'd0);
    hold(1, 0, 1, 0, 0, 3'd0);
    chk("idle_reaccept", 32'(octave), 32'd4);
    hold(2, 0, 0, 0, 0, 3'd0);

    // Decay held down at 0
    do_reset();
    pulses = 0;
    hold(30, 0, 0, 0, 1, 3'd2);
    hold(1, 0, 0, 0, 0, 3'd2);
    chk("decay_floor", 32'(decay), 32'd0);
    chk("decay_nopulse", 32'(pulses), 32'd0);

    // Amplitude auto-repeat: steps at 1, 11, 15, 19
    do_reset();
    pulses = 0;
    hold(20, 0, 0, 1, 0, 3'd0);
    hold(2, 0, 0, 0, 0, 3'd0);
    chk("amp_repeat", 32'(amplitude), 32'd1107296256);
    chk("amp_pulses", 32'(pulses), 32'd4);

    // Cancelling octave pair lets adsr_up through
    do_reset();
    hold(1, 1, 1, 1, 0, 3'd1);
    hold(2, 0, 0, 0, 0, 3'd1);
    chk("cancel_oct", 32'(octave), 32'd4);
    chk("cancel_attack", 32'(attack), 32'd1082130432);

    // Octave saturation at 7 during repeat
    do_reset();
    hold(1, 1, 0, 0, 0, 3'd0); hold(1, 0, 0, 0, 0, 3'd0);
    hold(1, 1, 0, 0, 0, 3'd0); hold(1, 0, 0, 0, 0, 3'd0);
    chk("oct_six", 32'(octave), 32'd6);
    pulses = 0;
    hold(RD + 3 * RP + 2, 1, 0, 0, 0, 3'd0);
    hold(1, 0, 0, 0, 0, 3'd0);
    chk("oct_sat", 32'(octave), 32'd7);
    chk("oct_sat_pulse", 32'(pulses), 32'd1);

    // Reset mid-repeat at what would be a step point
    do_reset();
    hold(51, 0, 0, 1, 0, 3'd3);
    chk("sus_140", 32'(sustain), 32'd1174405120);
    hold(3, 0, 0, 1, 0, 3'd3);
    cyc(1'b0, 0, 0, 1, 0, 3'd3);
    chk("sus_reset", 32'(sustain), 32'd1073741824);
    chk("sus_reset_chg", 32'(changed), 32'd0);
    hold(1, 0, 0, 1, 0, 3'd3);
    chk("sus_idle_accept", 32'(sustain), 32'd1082130432);
    hold(2, 0, 0, 0, 0, 3'd3);

    // Randomized holds with noise on other inputs and adsr_sel
    do_reset();
    for (int s = 0; s < 80; s++) begin
      base = 4'($urandom_range(0, 15));
      sel  = 3'($urandom_range(0, 7));
      len  = $urandom_range(1, 28);
      for (int c = 0; c < len; c++) begin
        noise = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
        if ($urandom_range(0, 2) == 0) sel = 3'($urandom_range(0, 7));
        cyc(($urandom_range(0, 60) != 0), base[3] | noise[3], base[2] | noise[2],
            base[1] | noise[1], base[0] | noise[0], sel);
      end
      hold($urandom_range(0, 2), 0, 0, 0, 0, sel);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
